// File: rtl/seq_mxn_shift_unit_pkg.sv
// Shared definitions for the multi-lane sequential shifter.
// Contents: shift mode codes, FSM state type, and a helper that sizes the
// per-lane shift amount field so it can hold the value WIDTH.
package seq_mxn_shift_unit_pkg;

  localparam logic [1:0] MODE_LOGICAL = 2'd0;
  localparam logic [1:0] MODE_ARITH   = 2'd1;
  localparam logic [1:0] MODE_ROTATE  = 2'd2;
  localparam logic [1:0] MODE_FILL    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int amt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mxn_shift_unit_if.sv
// Request/response bundle for seq_mxn_shift_unit.
// master: requester side (drives request, out_ready; observes results).
// slave : the shift unit (accepts request, drives results and status).
interface seq_mxn_shift_unit_if
  import seq_mxn_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SETS  = 2,
  parameter int AMT_W = amt_width(WIDTH)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SETS*WIDTH-1:0] in_packed;
  logic [SETS*AMT_W-1:0] amt_packed;
  logic                  shift_dir;
  logic [1:0]            mode;
  logic                  fill_bit;
  logic                  out_valid;
  logic                  out_ready;
  logic [SETS*WIDTH-1:0] out_packed;
  logic [SETS*WIDTH-1:0] overflow_packed;
  logic [SETS-1:0]       sign_change;
  logic                  busy;

  modport master (
    output in_valid, in_packed, amt_packed, shift_dir, mode, fill_bit, out_ready,
    input  in_ready, out_valid, out_packed, overflow_packed, sign_change, busy
  );

  modport slave (
    input  in_valid, in_packed, amt_packed, shift_dir, mode, fill_bit, out_ready,
    output in_ready, out_valid, out_packed, overflow_packed, sign_change, busy
  );
endinterface

// File: rtl/seq_mxn_shift_unit_shift_lane_step.sv
// One shifter lane: data, shifted-out bits, remaining-step counter and
// sticky sign-change flag, advancing one bit per enabled clock.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture data_in/amt (amount clamped to WIDTH)
//   step_en         unit is in its shifting phase
//   amt, data_in    per-lane request fields
//   dir, mode, fill_bit  common shift controls (held by the top)
//   data, ovf, sign_change  lane results
//   last            at most one step remaining (idle lanes report 1)
module shift_lane_step
  import seq_mxn_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = amt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step_en,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             fill_bit,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] ovf,
  output logic             sign_change,
  output logic             last
);

  logic [WIDTH-1:0] data_q, ovf_q, data_step, ovf_step;
  logic [AMT_W-1:0] cnt_q, cnt_load;
  logic             sc_q, in_bit, leave_bit;

  assign cnt_load = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

  always_comb begin
    leave_bit = dir ? data_q[0] : data_q[WIDTH-1];
    in_bit    = 1'b0;
    case (mode)
      MODE_ARITH:  in_bit = dir ? data_q[WIDTH-1] : 1'b0;
      MODE_ROTATE: in_bit = leave_bit;
      MODE_FILL:   in_bit = fill_bit;
      default:     in_bit = 1'b0;
    endcase
    if (dir) begin
      data_step = {in_bit, data_q[WIDTH-1:1]};
      ovf_step  = {data_q[0], ovf_q[WIDTH-1:1]};
    end else begin
      data_step = {data_q[WIDTH-2:0], in_bit};
      ovf_step  = {ovf_q[WIDTH-2:0], data_q[WIDTH-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ovf_q  <= '0;
      cnt_q  <= '0;
      sc_q   <= 1'b0;
    end else if (load) begin
      data_q <= data_in;
      ovf_q  <= '0;
      cnt_q  <= cnt_load;
      sc_q   <= 1'b0;
    end else if (step_en && (cnt_q != '0)) begin
      data_q <= data_step;
      ovf_q  <= ovf_step;
      cnt_q  <= cnt_q - 1'b1;
      // A left step moves data[W-2] into the MSB.
      if ((mode == MODE_ARITH) && !dir && (data_q[WIDTH-1] != data_q[WIDTH-2]))
        sc_q <= 1'b1;
    end
  end

  assign data        = data_q;
  assign ovf         = ovf_q;
  assign sign_change = sc_q;
  assign last        = (cnt_q <= AMT_W'(1));

endmodule

// File: rtl/seq_mxn_shift_unit.sv
// Multi-cycle, multi-lane shifter: SETS lanes of WIDTH bits, each shifted
// one bit per clock by its own amount, with overflow capture and an
// arithmetic sign-change flag.
//
//   state | meaning
//   IDLE  | ready for a request (in_ready=1)
//   SHIFT | lanes with steps remaining shift one bit per clock
//   DONE  | result valid, held until out_ready
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries
// the request handshake/fields, the result handshake/fields and busy.
module seq_mxn_shift_unit
  import seq_mxn_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SETS  = 2,
  parameter int AMT_W = amt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_mxn_shift_unit_if.slave  bus
);

  if (WIDTH < 2) begin : g_chk_width
    $error("seq_mxn_shift_unit: WIDTH must be >= 2");
  end
  if (SETS < 1) begin : g_chk_sets
    $error("seq_mxn_shift_unit: SETS must be >= 1");
  end

  state_t                state_q, state_d;
  logic                  dir_q, fill_q;
  logic [1:0]            mode_q;
  logic                  accept, step_en;
  logic [SETS-1:0]       lane_last, sc_w;
  logic [SETS*WIDTH-1:0] out_w, ovf_w;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign step_en = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = (|bus.amt_packed) ? SHIFT : DONE;
      SHIFT: if (&lane_last)   state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      mode_q  <= MODE_LOGICAL;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dir_q  <= bus.shift_dir;
        mode_q <= bus.mode;
        fill_q <= bus.fill_bit;
      end
    end
  end

  for (genvar g = 0; g < SETS; g++) begin : g_lane
    shift_lane_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .step_en     (step_en),
      .amt         (bus.amt_packed[g*AMT_W +: AMT_W]),
      .data_in     (bus.in_packed[g*WIDTH +: WIDTH]),
      .dir         (dir_q),
      .mode        (mode_q),
      .fill_bit    (fill_q),
      .data        (out_w[g*WIDTH +: WIDTH]),
      .ovf         (ovf_w[g*WIDTH +: WIDTH]),
      .sign_change (sc_w[g]),
      .last        (lane_last[g])
    );
  end

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.out_valid       = (state_q == DONE);
  assign bus.busy            = (state_q != IDLE);
  assign bus.out_packed      = out_w;
  assign bus.overflow_packed = ovf_w;
  assign bus.sign_change     = sc_w;

endmodule

// File: tb/tb_seq_mxn_shift_unit.sv
module tb_seq_mxn_shift_unit;
  localparam int W = 8;
  localparam int S = 2;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_mxn_shift_unit_if #(.WIDTH(W), .SETS(S), .AMT_W(A)) bus ();

  seq_mxn_shift_unit #(.WIDTH(W), .SETS(S), .AMT_W(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] din;
    logic [7:0]  amt;
    bit          dir;
    logic [1:0]  mode;
    bit          fill;
    logic [15:0] eo;
    logic [15:0] eovf;
    logic [1:0]  esc;
    int          elat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-shift arithmetic per lane, no step-by-step simulation.
  function automatic void lane_model(input int x, input int a, input bit dir,
                                     input int mode, input bit fill,
                                     output int o, output int v, output bit sc);
    int m, z, w, sx;
    m  = (1 << W) - 1;
    sc = 1'b0;
    if (!dir) begin
      v = (x >> (W - a)) & m;
      case (mode)
        2:       o = ((x << a) | (x >> (W - a))) & m;
        3:       o = ((x << a) | (fill ? ((1 << a) - 1) : 0)) & m;
        default: o = (x << a) & m;
      endcase
      if (mode == 1) begin
        z  = x << 1;
        w  = z >> (W - a);
        sc = (w != 0) && (w != ((1 << (a + 1)) - 1));
      end
    end else begin
      v = (x << (W - a)) & m;
      case (mode)
        1: begin
          sx = x[W-1] ? x - (1 << W) : x;
          o  = (sx >>> a) & m;
        end
        2:       o = ((x >> a) | (x << (W - a))) & m;
        3:       o = (x >> a) | (fill ? (m & ~(m >> a)) : 0);
        default: o = x >> a;
      endcase
    end
  endfunction

  function automatic void model_all(input logic [15:0] d, input logic [7:0] a,
                                    input bit dir, input logic [1:0] m, input bit f,
                                    output logic [15:0] eo, output logic [15:0] eovf,
                                    output logic [1:0] esc, output int elat);
    int o, v, aa, maxa;
    bit sc;
    maxa = 0;
    for (int i = 0; i < S; i++) begin
      aa = int'(a[i*A +: A]);
      if (aa > W) aa = W;
      if (aa > maxa) maxa = aa;
      lane_model(int'(d[i*W +: W]), aa, dir, int'(m), f, o, v, sc);
      eo[i*W +: W]   = o[W-1:0];
      eovf[i*W +: W] = v[W-1:0];
      esc[i]         = sc;
    end
    elat = maxa + 1;
  endfunction

  task automatic send(input logic [15:0] d, input logic [7:0] a, input bit dir,
                      input logic [1:0] m, input bit f);
    bus.in_packed  = d;
    bus.amt_packed = a;
    bus.shift_dir  = dir;
    bus.mode       = m;
    bus.fill_bit   = f;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_out_valid", bus.out_valid, 1'b0);
    check("release_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] d, input logic [7:0] a,
                         input bit dir, input logic [1:0] m, input bit f,
                         input logic [15:0] eo, input logic [15:0] eovf,
                         input logic [1:0] esc, input int elat, input int hold);
    int lat;
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    send(d, a, dir, m, f);
    wait_result(lat);
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_out"}, bus.out_packed, eo);
    check({tag, "_ovf"}, bus.overflow_packed, eovf);
    check({tag, "_sign"}, bus.sign_change, esc);
    release_result(hold);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] eo, eovf, d;
    logic [7:0]  a;
    logic [1:0]  esc, m;
    bit          dir, f;
    int          elat;

    vecs[0] = '{16'h0096, 8'h03, 1'b0, 2'd0, 1'b0, 16'h00B0, 16'h0004, 2'b00, 4};
    vecs[1] = '{16'h0081, 8'h02, 1'b1, 2'd1, 1'b0, 16'h00E0, 16'h0040, 2'b00, 3};
    vecs[2] = '{16'h00C3, 8'h02, 1'b0, 2'd2, 1'b0, 16'h000F, 16'h0003, 2'b00, 3};
    vecs[3] = '{16'h0040, 8'h01, 1'b0, 2'd1, 1'b0, 16'h0080, 16'h0000, 2'b01, 2};
    vecs[4] = '{16'hFF81, 8'hC1, 1'b0, 2'd0, 1'b0, 16'h0002, 16'hFF01, 2'b00, 9};
    vecs[5] = '{16'h5A3C, 8'h00, 1'b0, 2'd1, 1'b0, 16'h5A3C, 16'h0000, 2'b00, 1};
    vecs[6] = '{16'h12A5, 8'h88, 1'b1, 2'd2, 1'b0, 16'h12A5, 16'h12A5, 2'b00, 9};
    vecs[7] = '{16'h0000, 8'h03, 1'b1, 2'd3, 1'b1, 16'h00E0, 16'h0000, 2'b00, 4};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_packed = '0; bus.amt_packed = '0;
    bus.shift_dir = 1'b0; bus.mode = 2'd0; bus.fill_bit = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_out", bus.out_packed, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].din, vecs[i].amt, vecs[i].dir,
              vecs[i].mode, vecs[i].fill, vecs[i].eo, vecs[i].eovf,
              vecs[i].esc, vecs[i].elat, 0);

    // Backpressure: result holds, new requests ignored while DONE.
    send(16'h1234, 8'h11, 1'b0, 2'd0, 1'b0);
    model_all(16'h1234, 8'h11, 1'b0, 2'd0, 1'b0, eo, eovf, esc, elat);
    wait_result(elat);
    check("bp_out_valid", bus.out_valid, 1'b1);
    bus.in_packed = 16'hFFFF; bus.amt_packed = 8'h00; bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp_hold_out", bus.out_packed, eo);
      check("bp_hold_ovf", bus.overflow_packed, eovf);
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    release_result(0);
    @(posedge clk); #1;
    check("bp_no_accept_busy", bus.busy, 1'b0);
    check("bp_no_accept_out", bus.out_packed, eo);

    // Synchronous reset in the middle of a shift.
    send(16'hFFFF, 8'h88, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    check("midrst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_busy_clear", bus.busy, 1'b0);
    check("midrst_out", bus.out_packed, 16'h0);
    check("midrst_ovf", bus.overflow_packed, 16'h0);
    check("midrst_sign", bus.sign_change, 2'b00);
    repeat (10) begin @(posedge clk); #1; end
    check("midrst_stays_idle", bus.out_valid, 1'b0);

    // Randomized requests against the reference model.
    for (int t = 0; t < 60; t++) begin
      d   = 16'($urandom);
      a   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      dir = 1'($urandom);
      m   = 2'($urandom);
      f   = 1'($urandom);
      model_all(d, a, dir, m, f, eo, eovf, esc, elat);
      run_txn($sformatf("rand%0d", t), d, a, dir, m, f, eo, eovf, esc, elat,
              $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_mxn_shift_unit.md
Name: seq_mxn_shift_unit

Overview:
Multi-cycle, multi-lane shifter. Shifts SETS independent WIDTH-bit lanes by one bit per clock, with a per-lane shift amount.
- Modes: logical, arithmetic, rotate, or explicit fill bit.
- Captures shifted-out bits as per-lane overflow, plus an arithmetic sign-change flag.
- Valid/ready handshakes on input and output. Sits beside the combinational shifters as the area-cheap option for the ALU shift path.

Parameters:
WIDTH, 8, bit width of each lane (must be >= 2; otherwise $error at elaboration)
SETS, 2, number of lanes (must be >= 1; otherwise $error at elaboration)
AMT_W, $clog2(WIDTH+1), width of each lane's shift amount

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_packed  input  SETS*WIDTH  lane i at [i*WIDTH +: WIDTH]
amt_packed  input  SETS*AMT_W  lane i amount at [i*AMT_W +: AMT_W]
shift_dir  input  1  0 = left, 1 = right (common to all lanes)
mode  input  2  0 logical, 1 arithmetic, 2 rotate, 3 fill (common)
fill_bit  input  1  shifted-in bit when mode = 3
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_packed  output  SETS*WIDTH  shifted lanes
overflow_packed  output  SETS*WIDTH  shifted-out bits per lane
sign_change  output  SETS  per lane: MSB changed during an arithmetic left shift
busy  output  1  state != IDLE

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high.
- FSM states: IDLE, SHIFT, DONE.
- Reset (including mid-SHIFT or mid-DONE):
  - Next state IDLE; in-flight request discarded.
  - out_valid=0, in_ready=1, busy=0.
  - out_packed, overflow_packed, sign_change = 0.
- IDLE: in_ready=1. On in_valid:
  - Load data, shift_dir, mode, fill_bit.
  - Load per-lane counters with min(amt, WIDTH); amounts above WIDTH clamp to WIDTH.
  - Clear overflow and sign_change.
  - Next state SHIFT if any counter is nonzero, else DONE.
- in_ready=0 outside IDLE; in_valid is ignored there.
- SHIFT: each edge, every lane with counter>0 performs one step and decrements its counter. Lanes at 0 hold.
  - Left step: data = {data[W-2:0], in_bit}; ovf = {ovf[W-2:0], data[W-1]}.
  - Right step: data = {in_bit, data[W-1:1]}; ovf = {data[0], ovf[W-1:1]}.
  - in_bit:
    - logical: 0
    - arithmetic: left 0, right data[W-1]
    - rotate: the bit leaving the lane
    - fill: fill_bit
  - Rotate by WIDTH returns the original data, with ovf = original data.
  - sign_change[i] sets (sticky) when mode=1, left, and the step changes data[W-1].
  - Go to DONE on the edge where all counters reach 0.
- Latency: result visible max(amt_clamped)+1 cycles after the accept cycle. An amount of 0 gives 1 cycle.
- DONE: out_valid=1; outputs hold stable while out_ready=0. On out_ready: next state IDLE, out_valid=0. There is no same-cycle re-accept.
- Outputs are registered and change only on accept, during SHIFT, or on reset.
- Equivalence: overflow equals in>>(W-amt) for left and in<<(W-amt) for right, matching the combinational shifters.

Decomposition:
- Shared package holds:
  - mode constants MODE_LOGICAL/ARITH/ROTATE/FILL
  - state enum IDLE/SHIFT/DONE
  - AMT_W helper function
- One sub-module, shift_lane_step: a single lane's data, ovf, counter, sign_change registers and step logic. Instantiated SETS times in a generate loop.
- The top holds the FSM, handshakes and packing.

Test Plan:
- Logical left, lane0=8'b1001_0110, amt=3 -> out 8'b1011_0000, ovf 8'b0000_0100; out_valid 4 cycles after accept.
- Arithmetic right, lane0=8'b1000_0001, amt=2 -> out 8'b1110_0000, ovf 8'b0100_0000.
- Rotate left, 8'b1100_0011, amt=2 -> out 8'b0000_1111, ovf 8'b0000_0011.
- Arithmetic left, 8'b0100_0000, amt=1 -> out 8'b1000_0000, sign_change[0]=1.
- Per-lane amounts and clamp:
  - lane0 amt=1, lane1=8'hFF with amt=12 logical left -> lane1 out 8'h00, ovf 8'hFF.
  - Lane0 holds after 1 step; out_valid after 9 cycles.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0, in_valid ignored.
  - rst pulse mid-SHIFT -> next cycle IDLE, out_valid=0, in_ready=1, outputs 0.
